// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   IcacheIndexBits : default line-index width (2**6 = 64 one-word lines)
//   icache_state_e  : controller FSM encoding (3-bit)
package icache_pkg;

   localparam int unsigned IcacheIndexBits = 6;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLookup = 3'd1,
      StMiss   = 3'd2,
      StDrain  = 3'd3,
      StResp   = 3'd4
   } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Line storage for icache: valid bits (async reset) plus tag and data arrays (no reset).
//   clk, rst_n      : clock, asynchronous active-low reset (clears valid bits only)
//   rd_idx_i        : read index; rd_valid_o/rd_tag_o/rd_data_o are combinational
//   we_i            : write strobe; writes wr_tag_i/wr_data_i at wr_idx_i and sets valid
module icache_line_array
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = IcacheIndexBits,
   parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [31:0]           rd_data_o,
   input  logic                  we_i,
   input  logic [INDEX_BITS-1:0] wr_idx_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [31:0]           wr_data_i
);

   localparam int unsigned Lines = 1 << INDEX_BITS;

   logic [Lines-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [Lines];
   logic [31:0]         data_q [Lines];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Fill and lookup never happen in the same cycle, so no read bypass is needed.
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
//   clk, rst_n           : clock, asynchronous active-low reset
//   rdy                  : global enable; low freezes all state and outputs
//   flush                : abandons the current fetch (lines stay valid)
//   if_req/if_addr       : fetch request, held until if_valid
//   if_valid/if_instr    : one-cycle response pulse with the instruction word
//   mc_req/mc_addr       : fetch request to the memory controller (held until mc_valid)
//   mc_valid/mc_data     : one-cycle return from the memory controller
module icache
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = IcacheIndexBits
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic        mc_req,
   output logic [31:0] mc_addr,
   input  logic        mc_valid,
   input  logic [31:0] mc_data
);

   localparam int unsigned TagBits = 30 - INDEX_BITS;

   icache_state_e state_q, state_d;
   logic [29:0]   req_addr_q, req_addr_d;  // word address of the accepted request
   logic          if_valid_q, if_valid_d;
   logic [31:0]   if_instr_q, if_instr_d;
   logic          mc_req_q, mc_req_d;
   logic [31:0]   mc_addr_q, mc_addr_d;
   logic          fill;

   logic                  rd_valid;
   logic [TagBits-1:0]    rd_tag;
   logic [31:0]           rd_data;
   logic [INDEX_BITS-1:0] req_idx;
   logic [TagBits-1:0]    req_tag;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^if_addr[1:0];
   assign req_idx = req_addr_q[INDEX_BITS-1:0];
   assign req_tag = req_addr_q[29:INDEX_BITS];

   icache_line_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TagBits)
   ) u_lines (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (req_idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .we_i       (fill & rdy),
      .wr_idx_i   (req_idx),
      .wr_tag_i   (req_tag),
      .wr_data_i  (mc_data)
   );

   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      mc_req_d   = mc_req_q;
      mc_addr_d  = mc_addr_q;
      fill       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (if_req && !flush) begin
               req_addr_d = if_addr[31:2];
               state_d    = StLookup;
            end
         end
         StLookup: begin
            if (flush) begin
               state_d = StIdle;
            end else if (rd_valid && (rd_tag == req_tag)) begin
               if_instr_d = rd_data;
               if_valid_d = 1'b1;
               state_d    = StResp;
            end else begin
               mc_req_d  = 1'b1;
               mc_addr_d = {req_addr_q, 2'b00};
               state_d   = StMiss;
            end
         end
         StMiss: begin
            // A return always fills the line; flush only suppresses the response.
            if (mc_valid) begin
               fill     = 1'b1;
               mc_req_d = 1'b0;
               if (flush) begin
                  state_d = StIdle;
               end else begin
                  if_instr_d = mc_data;
                  if_valid_d = 1'b1;
                  state_d    = StResp;
               end
            end else if (flush) begin
               // The controller has no accept signal, so the request must run to completion.
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (mc_valid) begin
               fill     = 1'b1;
               mc_req_d = 1'b0;
               state_d  = StIdle;
            end
         end
         StResp: begin
            if_valid_d = 1'b0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         req_addr_q <= '0;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         mc_req_q   <= 1'b0;
         mc_addr_q  <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         mc_req_q   <= mc_req_d;
         mc_addr_q  <= mc_addr_d;
      end
   end

   assign if_valid = if_valid_q;
   assign if_instr = if_instr_q;
   assign mc_req   = mc_req_q;
   assign mc_addr  = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a memory-controller model and an if_instr scoreboard.
module tb_icache;

   logic        clk;
   logic        rst_n;
   logic        rdy;
   logic        flush;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        mc_req;
   logic [31:0] mc_addr;
   logic        mc_valid;
   logic [31:0] mc_data;

   int checks = 0;
   int failures = 0;

   // controller model state
   bit          ctl_auto = 1'b1;
   int          ctl_lat = 5;
   bit          busy = 1'b0;
   int          cnt = 0;
   int          n_req = 0;
   logic [31:0] last_mc_addr = '0;

   // scoreboard
   logic [31:0] exp_q[$];
   int          n_valid = 0;

   icache dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rdy      (rdy),
      .flush    (flush),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .mc_req   (mc_req),
      .mc_addr  (mc_addr),
      .mc_valid (mc_valid),
      .mc_data  (mc_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1004) return 32'h0051_0113;
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory controller: returns the word ctl_lat cycles after seeing mc_req.
   initial begin
      forever begin
         @(negedge clk);
         if (ctl_auto) begin
            if (mc_valid) begin
               mc_valid = 1'b0;
               check("mc_req_low_after_valid", {31'b0, mc_req}, 32'd0);
               busy = 1'b0;
            end else if (mc_req === 1'b1) begin
               if (!busy) begin
                  busy = 1'b1;
                  cnt = 0;
                  n_req++;
                  last_mc_addr = mc_addr;
               end else begin
                  check("mc_addr_stable", mc_addr, last_mc_addr);
               end
               cnt++;
               if (cnt == ctl_lat) begin
                  mc_valid = 1'b1;
                  mc_data = mem_word(last_mc_addr);
               end
            end else begin
               busy = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: every if_valid pulse consumes one expected word.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (if_valid === 1'b1) begin
            n_valid++;
            check("sb_pending", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("if_instr", if_instr, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input bit miss);
      int n_req0;
      int cyc;
      n_req0 = n_req;
      exp_q.push_back(exp_data);
      @(negedge clk);
      if_req = 1'b1;
      if_addr = addr;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (if_valid === 1'b1) break;
      end
      check("fetch_done", {31'b0, if_valid}, 32'd1);
      if_req = 1'b0;
      check("latency", cyc, miss ? 32'(2 + ctl_lat) : 32'd2);
      check("mc_req_count", n_req - n_req0, miss ? 32'd1 : 32'd0);
      if (miss) check("mc_addr", last_mc_addr, {addr[31:2], 2'b00});
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_mc_req();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (mc_req === 1'b1) break;
      end
      check("mc_req_raised", {31'b0, mc_req}, 32'd1);
   endtask

   initial begin
      int nv0;
      rst_n = 1'b0;
      rdy = 1'b1;
      flush = 1'b0;
      if_req = 1'b0;
      if_addr = '0;
      mc_valid = 1'b0;
      mc_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_if_valid", {31'b0, if_valid}, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
      check("rst_mc_req", {31'b0, mc_req}, 32'd0);
      check("rst_mc_addr", mc_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // cold miss, then hit
      fetch(32'h0000_1004, 32'h0051_0113, 1'b1);
      fetch(32'h0000_1004, 32'h0051_0113, 1'b0);
      // conflict on index 1
      fetch(32'h0000_1104, mem_word(32'h0000_1104), 1'b1);
      fetch(32'h0000_1004, 32'h0051_0113, 1'b1);

      // flush in MISS: request drains, no response, line still filled
      nv0 = n_valid;
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'h0000_2008;
      wait_mc_req();
      @(negedge clk);
      flush = 1'b1;
      if_req = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      check("drain_mc_req", {31'b0, mc_req}, 32'd1);
      check("drain_mc_addr", mc_addr, 32'h0000_2008);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("drain_done", {31'b0, mc_req}, 32'd0);
      repeat (2) @(negedge clk);
      check("drain_no_if_valid", n_valid - nv0, 32'd0);
      fetch(32'h0000_2008, mem_word(32'h0000_2008), 1'b0);

      // rdy low mid-MISS with mc_valid and flush coincident
      ctl_auto = 1'b0;
      nv0 = n_valid;
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'h0000_3010;
      wait_mc_req();
      @(negedge clk);
      rdy = 1'b0;
      mc_valid = 1'b1;
      mc_data = 32'hCAFE_3010;
      flush = 1'b1;
      if_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("frz_mc_req", {31'b0, mc_req}, 32'd1);
         check("frz_mc_addr", mc_addr, 32'h0000_3010);
         check("frz_if_valid", {31'b0, if_valid}, 32'd0);
      end
      @(negedge clk);
      rdy = 1'b1;
      @(posedge clk);
      #1;
      check("coinc_mc_req_low", {31'b0, mc_req}, 32'd0);
      check("coinc_if_valid", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      mc_valid = 1'b0;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      check("coinc_no_if_valid", n_valid - nv0, 32'd0);
      ctl_auto = 1'b1;
      fetch(32'h0000_3010, 32'hCAFE_3010, 1'b0);

      // async reset mid-MISS
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'h0000_4000;
      wait_mc_req();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_mc_req", {31'b0, mc_req}, 32'd0);
      check("arst_mc_addr", mc_addr, 32'd0);
      check("arst_if_valid", {31'b0, if_valid}, 32'd0);
      check("arst_if_instr", if_instr, 32'd0);
      if_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fetch(32'h0000_2008, mem_word(32'h0000_2008), 1'b1);
      fetch(32'h0000_2008, mem_word(32'h0000_2008), 1'b0);

      repeat (3) @(negedge clk);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
